// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MDU opcode encodings and default latencies
package mdu_defs;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage MDU request/result bundle
interface e_mdu_if;
  logic        Req;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_O;

  modport master (output Req, Start, MDUOp, A, B, input Busy, HI, LO, MDU_O);
  modport slave  (input Req, Start, MDUOp, A, B, output Busy, HI, LO, MDU_O);
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle mult/div unit owning architectural HI/LO
module e_mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  e_mdu_if.slave bus
);

  logic [3:0]  r_cnt;
  logic        r_busy;
  mdu_op_e     r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den_u;
  logic [31:0] w_den_m;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_we;

  assign w_accept = bus.Start & ~bus.Req & ~r_busy;

  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  assign w_div_zero = (r_b == 32'd0);
  assign w_mag_a    = r_a[31] ? -r_a : r_a;
  assign w_mag_b    = r_b[31] ? -r_b : r_b;
  assign w_den_u    = w_div_zero ? 32'd1 : r_b;
  assign w_den_m    = w_div_zero ? 32'd1 : w_mag_b;
  assign w_sq_mag   = w_mag_a / w_den_m;
  assign w_sr_mag   = w_mag_a % w_den_m;
  assign w_sq       = (r_a[31] ^ r_b[31]) ? -w_sq_mag : w_sq_mag;
  assign w_sr       = r_a[31] ? -w_sr_mag : w_sr_mag;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_we = 1'b0;
    case (r_op)
      MDU_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; w_res_we = 1'b1; end
      MDU_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; w_res_we = 1'b1; end
      MDU_DIV:   begin w_res_hi = w_sr; w_res_lo = w_sq; w_res_we = ~w_div_zero; end
      MDU_DIVU:  begin w_res_hi = r_a % w_den_u; w_res_lo = r_a / w_den_u; w_res_we = ~w_div_zero; end
      default:   w_res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
      r_op   <= MDU_NONE;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        if (w_res_we) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end else if (w_accept) begin
      case (bus.MDUOp)
        MDU_MULT, MDU_MULTU: begin
          r_op   <= mdu_op_e'(bus.MDUOp);
          r_a    <= bus.A;
          r_b    <= bus.B;
          r_cnt  <= 4'(MULT_CYCLES);
          r_busy <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          r_op   <= mdu_op_e'(bus.MDUOp);
          r_a    <= bus.A;
          r_b    <= bus.B;
          r_cnt  <= 4'(DIV_CYCLES);
          r_busy <= 1'b1;
        end
        MDU_MTHI: r_hi <= bus.A;
        MDU_MTLO: r_lo <= bus.A;
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    bus.MDU_O = 32'd0;
    case (bus.MDUOp)
      MDU_MFHI: bus.MDU_O = r_hi;
      MDU_MFLO: bus.MDU_O = r_lo;
      default:  bus.MDU_O = 32'd0;
    endcase
  end

  assign bus.Busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
